dtb_rd_port: RTL and testbench



---
 rtl/dtb_rd_port.sv | 162 ++++++++++++++++
 tb/tb_dtb_rd_port.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dtb_rd_port.sv
// Bus-side read port for the device-tree ROM: sized single/burst reads with registered response beats.
// Optional DTB_ERR_EN adds rsp_err_o for out-of-range words and misaligned requests.
module dtb_rd_port #(
  parameter int unsigned ROM_WORDS = 240,
  parameter int unsigned AW        = 12,
  parameter int unsigned LW        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [AW-1:0]   req_addr_i,
  input  logic            req_size_i,
  input  logic [LW-1:0]   req_len_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [63:0]     rsp_data_o,
  output logic            rsp_last_o,
`ifdef DTB_ERR_EN
  output logic            rsp_err_o,
`endif
  output logic [AW-4:0]   rom_addr_o,
  input  logic [63:0]     rom_data_i
);

  localparam int unsigned WIW = AW - 3;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic            size_q, size_d;
  logic [LW-1:0]   beats_left_q, beats_left_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic            rsp_last_q, rsp_last_d;
  logic [WIW-1:0]  rom_addr_q, rom_addr_d;

  logic [AW-1:0]   iss_addr;
  logic            iss_size;
  logic [LW-1:0]   iss_left;
  logic            issue;
  logic [WIW-1:0]  iss_word;
  logic            iss_oor;
  logic [63:0]     word_data;
  logic [63:0]     beat_data;

`ifdef DTB_ERR_EN
  logic            mis_q, mis_d;
  logic            rsp_err_q, rsp_err_d;
  logic            iss_mis;
`else
  logic            addr_lsb_unused;
  assign addr_lsb_unused = ^req_addr_i[1:0];
`endif

  // Beat source: the request itself when accepting in IDLE, else the running burst cursor.
  always_comb begin
    iss_addr = cur_addr_q;
    iss_size = size_q;
    iss_left = beats_left_q;
    issue    = 1'b0;
`ifdef DTB_ERR_EN
    iss_mis  = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        iss_size = req_size_i;
        iss_addr = req_size_i ? {req_addr_i[AW-1:3], 3'b000} : {req_addr_i[AW-1:2], 2'b00};
        iss_left = req_len_i;
        issue    = req_valid_i;
`ifdef DTB_ERR_EN
        iss_mis  = req_size_i ? (req_addr_i[2:0] != 3'b000) : (req_addr_i[1:0] != 2'b00);
`endif
      end
      S_BURST: issue = !rsp_valid_q || rsp_ready_i;
      default: issue = 1'b0;
    endcase
  end

  assign iss_word   = iss_addr[AW-1:3];
  assign iss_oor    = 32'(iss_word) >= ROM_WORDS;
  assign word_data  = iss_oor ? 64'h0 : rom_data_i;
  assign beat_data  = iss_size ? word_data
                               : {32'h0, (iss_addr[2] ? word_data[63:32] : word_data[31:0])};
  assign rom_addr_o = (state_q == S_BURST || issue) ? iss_word : rom_addr_q;

  // Next-state and output-register update.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    size_d       = size_q;
    beats_left_d = beats_left_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_last_d   = rsp_last_q;
    rom_addr_d   = rom_addr_o;
`ifdef DTB_ERR_EN
    mis_d        = mis_q;
    rsp_err_d    = rsp_err_q;
`endif
    if (issue) begin
      rsp_valid_d  = 1'b1;
      rsp_data_d   = beat_data;
      rsp_last_d   = (iss_left == '0);
      cur_addr_d   = iss_addr + (iss_size ? AW'(8) : AW'(4));
      size_d       = iss_size;
      beats_left_d = iss_left - LW'(1);
      state_d      = (iss_left == '0) ? S_DRAIN : S_BURST;
`ifdef DTB_ERR_EN
      mis_d        = iss_mis;
      rsp_err_d    = iss_oor || iss_mis;
`endif
    end else if (state_q == S_DRAIN && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
      state_d     = S_IDLE;
    end
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      size_q       <= 1'b0;
      beats_left_q <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_last_q   <= 1'b0;
      rom_addr_q   <= '0;
`ifdef DTB_ERR_EN
      mis_q        <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      size_q       <= size_d;
      beats_left_q <= beats_left_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_last_q   <= rsp_last_d;
      rom_addr_q   <= rom_addr_d;
`ifdef DTB_ERR_EN
      mis_q        <= mis_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;
`ifdef DTB_ERR_EN
  assign rsp_err_o   = rsp_err_q;
`endif

endmodule

// File: tb/tb_dtb_rd_port.sv
// Directed testbench for dtb_rd_port with a small combinational ROM stand-in.
module tb_dtb_rd_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [11:0] req_addr;
  logic        req_size;
  logic [3:0]  req_len;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_last;
`ifdef DTB_ERR_EN
  logic        rsp_err;
`endif
  logic [8:0]  rom_addr;
  logic [63:0] rom_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] tp_exp [16];

  dtb_rd_port dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_len_i(req_len),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
`ifdef DTB_ERR_EN
    .rsp_err_o(rsp_err),
`endif
    .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;

  // ROM stand-in: a few fixed words, a recognisable pattern elsewhere (including past ROM_WORDS).
  function automatic logic [63:0] rom_word(input logic [8:0] w);
    case (w)
      9'd0:    rom_word = 64'h79070000edfe0dd0;
      9'd1:    rom_word = 64'hd005000038000000;
      9'd13:   rom_word = 64'h0400000003000000;
      9'd14:   rom_word = 64'h0200000000000000;
      9'd15:   rom_word = 64'h0400000003000000;
      9'd239:  rom_word = 64'hEF00EF0000EF00EF;
      default: rom_word = {32'hC0DE0000 | 32'(w), 32'h5A5A0000 | 32'(w)};
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [11:0] a, input logic s, input logic [3:0] l);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_len   = l;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [63:0] d, input logic l);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(1'b1));
    chk({tag, "_data"},  rsp_data, d);
    chk({tag, "_last"},  64'(rsp_last), 64'(l));
    tick();
  endtask

  initial begin
    tp_exp[0]  = 64'h79070000edfe0dd0;  tp_exp[1]  = 64'hd005000038000000;
    tp_exp[2]  = 64'hC0DE00025A5A0002;  tp_exp[3]  = 64'hC0DE00035A5A0003;
    tp_exp[4]  = 64'hC0DE00045A5A0004;  tp_exp[5]  = 64'hC0DE00055A5A0005;
    tp_exp[6]  = 64'hC0DE00065A5A0006;  tp_exp[7]  = 64'hC0DE00075A5A0007;
    tp_exp[8]  = 64'hC0DE00085A5A0008;  tp_exp[9]  = 64'hC0DE00095A5A0009;
    tp_exp[10] = 64'hC0DE000A5A5A000A;  tp_exp[11] = 64'hC0DE000B5A5A000B;
    tp_exp[12] = 64'hC0DE000C5A5A000C;  tp_exp[13] = 64'h0400000003000000;
    tp_exp[14] = 64'h0200000000000000;  tp_exp[15] = 64'h0400000003000000;

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = 1'b0; req_len = '0; rsp_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_req_ready", 64'(req_ready), 64'(1'b1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    chk("rst_rsp_data",  rsp_data, 64'h0);
    chk("rst_rsp_last",  64'(rsp_last), 64'(1'b0));
    chk("rst_rom_addr",  64'(rom_addr), 64'h0);

    // Single 64-bit read, one-cycle latency, then back to IDLE.
    do_req(12'h000, 1'b1, 4'd0);
    chk("single_req_ready", 64'(req_ready), 64'(1'b0));
    expect_beat("single", 64'h79070000edfe0dd0, 1'b1);
    chk("single_done_valid", 64'(rsp_valid), 64'(1'b0));
    chk("single_done_ready", 64'(req_ready), 64'(1'b1));

    // 32-bit burst walking both halves of words 0 and 1.
    do_req(12'h000, 1'b0, 4'd3);
    expect_beat("b32_0", 64'h00000000edfe0dd0, 1'b0);
    expect_beat("b32_1", 64'h0000000079070000, 1'b0);
    expect_beat("b32_2", 64'h0000000038000000, 1'b0);
    expect_beat("b32_3", 64'h00000000d0050000, 1'b1);

    // Backpressure on the first beat of a 64-bit burst.
    rsp_ready = 1'b0;
    do_req(12'h068, 1'b1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 64'(rsp_valid), 64'(1'b1));
      chk("bp_hold_data",  rsp_data, 64'h0400000003000000);
      chk("bp_hold_rom",   64'(rom_addr), 64'd14);
      tick();
    end
    rsp_ready = 1'b1;
    expect_beat("bp_0", 64'h0400000003000000, 1'b0);
    expect_beat("bp_1", 64'h0200000000000000, 1'b0);
    expect_beat("bp_2", 64'h0400000003000000, 1'b1);
    chk("bp_done_valid", 64'(rsp_valid), 64'(1'b0));

    // Last populated word then first out-of-range word.
`ifdef DTB_ERR_EN
    do_req(12'h778, 1'b1, 4'd1);
    chk("oor_err0", 64'(rsp_err), 64'(1'b0));
    expect_beat("oor_0", 64'hEF00EF0000EF00EF, 1'b0);
    chk("oor_err1", 64'(rsp_err), 64'(1'b1));
    expect_beat("oor_1", 64'h0, 1'b1);
`else
    do_req(12'h778, 1'b1, 4'd1);
    expect_beat("oor_0", 64'hEF00EF0000EF00EF, 1'b0);
    expect_beat("oor_1", 64'h0, 1'b1);
`endif

    // Address wrap: word 511 (out of range) then word 0.
    do_req(12'hFF8, 1'b1, 4'd1);
    expect_beat("wrap_0", 64'h0, 1'b0);
    expect_beat("wrap_1", 64'h79070000edfe0dd0, 1'b1);

    // Misaligned starts are truncated to the access size.
    do_req(12'h00C, 1'b1, 4'd0);
    expect_beat("mis64", 64'hd005000038000000, 1'b1);
    do_req(12'h006, 1'b0, 4'd0);
    expect_beat("mis32", 64'h0000000079070000, 1'b1);

    // Full-throughput 16-beat burst with ready held high.
    do_req(12'h000, 1'b1, 4'd15);
    for (int i = 0; i < 16; i++) begin
      chk("tp_req_ready", 64'(req_ready), 64'(1'b0));
      expect_beat("tp", tp_exp[i], (i == 15));
    end
    chk("tp_done_valid", 64'(rsp_valid), 64'(1'b0));
    chk("tp_done_ready", 64'(req_ready), 64'(1'b1));

    // Asynchronous reset in the middle of a burst, then a fresh request.
    do_req(12'h000, 1'b1, 4'd15);
    expect_beat("mr_0", tp_exp[0], 1'b0);
    expect_beat("mr_1", tp_exp[1], 1'b0);
    expect_beat("mr_2", tp_exp[2], 1'b0);
    reset = 1'b1;
    #1;
    chk("mr_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    chk("mr_req_ready", 64'(req_ready), 64'(1'b1));
    chk("mr_rsp_data",  rsp_data, 64'h0);
    chk("mr_rsp_last",  64'(rsp_last), 64'(1'b0));
    #2;
    reset = 1'b0;
    tick();
    do_req(12'h010, 1'b1, 4'd1);
    expect_beat("post_0", 64'hC0DE00025A5A0002, 1'b0);
    expect_beat("post_1", 64'hC0DE00035A5A0003, 1'b1);
    chk("post_done_valid", 64'(rsp_valid), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
